// File: rtl/fp_mult_pipe_if.sv
// rtl/fp_mult_pipe_if.sv - operand/result handshake bundle for the pipelined FP multiplier
interface fp_mult_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic         clear;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, input_a, input_b, clear, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, input_a, input_b, clear, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - 3-stage IEEE-style multiplier: classify/exp sum, mantissa multiply, round/pack
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic           clk,
    input logic           reset_b,
    fp_mult_pipe_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EW   = EXP_W + 2;
    localparam int MW   = MAN_W + 1;
    localparam int PW   = 2 * MW;

    localparam logic [1:0] CLS_NUM  = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // All three stages move together; a held output freezes the whole pipe.
    logic advance;
    assign advance      = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = advance;

    logic               sign_a, sign_b;
    logic [EXP_W-1:0]   exp_a, exp_b;
    logic [MAN_W-1:0]   man_a, man_b;
    logic               zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic [1:0]         cls_n;
    logic signed [EW-1:0] exp_sum;

    assign {sign_a, exp_a, man_a} = bus.input_a;
    assign {sign_b, exp_b, man_b} = bus.input_b;

    // Exponent field 0 is zero: subnormals are flushed.
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign inf_a  = (&exp_a) && (man_a == '0);
    assign inf_b  = (&exp_b) && (man_b == '0);
    assign nan_a  = (&exp_a) && (man_a != '0);
    assign nan_b  = (&exp_b) && (man_b != '0);

    always_comb begin
        if (nan_a || nan_b || (zero_a && inf_b) || (inf_a && zero_b)) cls_n = CLS_NAN;
        else if (inf_a || inf_b)                                     cls_n = CLS_INF;
        else if (zero_a || zero_b)                                   cls_n = CLS_ZERO;
        else                                                         cls_n = CLS_NUM;
    end

    assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - $signed(EW'(BIAS));

    logic                 s1_valid, s1_sign;
    logic [1:0]           s1_cls;
    logic signed [EW-1:0] s1_exp;
    logic [MW-1:0]        s1_man_a, s1_man_b;

    logic                 s2_valid, s2_sign;
    logic [1:0]           s2_cls;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;

    logic                 out_valid_q;
    logic [W-1:0]         result_q;
    logic [3:0]           flags_q;

    logic [PW-2:0]        norm;
    logic [MAN_W-1:0]     mant;
    logic                 guard, sticky, round_up;
    logic [MAN_W:0]       mant_r;
    logic signed [EW-1:0] exp_fin;
    logic [W-1:0]         result_n;
    logic [3:0]           flags_n;

    // Product lies in [1,4); align so the leading one sits just above the kept mantissa.
    always_comb begin
        norm     = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
        mant     = norm[PW-2 -: MAN_W];
        guard    = norm[PW-2-MAN_W];
        sticky   = |norm[PW-3-MAN_W:0];
        round_up = guard && (sticky || mant[0]);
        mant_r   = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
        exp_fin  = s2_exp + $signed({{(EW-1){1'b0}}, s2_prod[PW-1]})
                          + $signed({{(EW-1){1'b0}}, mant_r[MAN_W]});
        result_n = '0;
        flags_n  = '0;
        case (s2_cls)
            CLS_NAN: begin
                result_n = QNAN;
                flags_n  = 4'b1000;
            end
            CLS_INF:  result_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_ZERO: result_n = {s2_sign, {(W-1){1'b0}}};
            default: begin
                if (exp_fin >= EXP_MAX) begin
                    result_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_n  = 4'b0101;
                end else if (exp_fin <= 0) begin
                    result_n = {s2_sign, {(W-1){1'b0}}};
                    flags_n  = 4'b0011;
                end else begin
                    result_n = {s2_sign, exp_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
                    flags_n  = {3'b000, guard || sticky};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_cls      <= '0;
            s1_exp      <= '0;
            s1_man_a    <= '0;
            s1_man_b    <= '0;
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_cls      <= '0;
            s2_exp      <= '0;
            s2_prod     <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            if (bus.clear) begin
                s1_valid    <= 1'b0;
                s2_valid    <= 1'b0;
                out_valid_q <= 1'b0;
            end else if (advance) begin
                s1_valid    <= bus.in_valid;
                s2_valid    <= s1_valid;
                out_valid_q <= s2_valid;
            end
            if (advance) begin
                s1_sign  <= sign_a ^ sign_b;
                s1_cls   <= cls_n;
                s1_exp   <= exp_sum;
                s1_man_a <= {1'b1, man_a};
                s1_man_b <= {1'b1, man_b};
                s2_sign  <= s1_sign;
                s2_cls   <= s1_cls;
                s2_exp   <= s1_exp;
                s2_prod  <= PW'(s1_man_a) * PW'(s1_man_b);
                result_q <= result_n;
                flags_q  <= flags_n;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - scoreboard bench for fp_mult_pipe at EXP_W=8, MAN_W=23
module tb_fp_mult_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic clk = 1'b0;
    logic reset_b;
    always #5 clk = ~clk;

    fp_mult_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
    fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [W+3:0] sb[$];
    logic [W-1:0] a_tab[16];
    logic [W-1:0] b_tab[16];
    logic [W-1:0] r_tab[16];
    logic [3:0]   f_tab[16];

    task automatic set_vec(input int k, input logic [W-1:0] a, b, r, input logic [3:0] f);
        a_tab[k] = a; b_tab[k] = b; r_tab[k] = r; f_tab[k] = f;
    endtask

    task automatic init_tables();
        set_vec(0,  32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        set_vec(1,  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        set_vec(2,  32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
        set_vec(3,  32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000);
        set_vec(4,  32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
        set_vec(5,  32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
        set_vec(6,  32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000);
        set_vec(7,  32'hFF800000, 32'hC0000000, 32'h7F800000, 4'b0000);
        set_vec(8,  32'h80000000, 32'h40400000, 32'h80000000, 4'b0000);
        set_vec(9,  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        set_vec(10, 32'h3F800801, 32'h3F800801, 32'h3F801003, 4'b0001);
        set_vec(11, 32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001);
        set_vec(12, 32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001);
        set_vec(13, 32'h00400000, 32'h40000000, 32'h00000000, 4'b0000);
        set_vec(14, 32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000);
        set_vec(15, 32'hC0000000, 32'h00000000, 32'h80000000, 4'b0000);
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] a, b, input logic ordy, input logic clr);
        bus.in_valid  = iv;
        bus.input_a   = a;
        bus.input_b   = b;
        bus.out_ready = ordy;
        bus.clear     = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
        checks++;
        if (bus.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", bus.flags); end
        reset_b = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_latency();
        drive(1'b1, a_tab[0], b_tab[0], 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            checks++;
            if (bus.out_valid !== (e == 3)) begin
                errors++;
                $display("FAIL latency_valid_edge%0d: got %b expected %b", e, bus.out_valid, (e == 3));
            end
            if (e < 3) tick();
        end
        checks++;
        if (bus.result !== r_tab[0] || bus.flags !== f_tab[0]) begin
            errors++;
            $display("FAIL latency_result: got %h/%b expected %h/%b", bus.result, bus.flags, r_tab[0], f_tab[0]);
        end
        tick();
    endtask

    task automatic test_vectors();
        int i;
        logic [W+3:0] exp_v;
        i = 0;
        for (int c = 0; c < 100 && (i < 16 || sb.size() > 0); c++) begin
            drive(i < 16, a_tab[i % 16], b_tab[i % 16], 1'b1, 1'b0);
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back({r_tab[i], f_tab[i]});
                i++;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL vec_unexpected: got %h expected no output", bus.result);
                end else begin
                    exp_v = sb.pop_front();
                    if ({bus.result, bus.flags} !== exp_v) begin
                        errors++;
                        $display("FAIL vec_result: got %h/%b expected %h/%b", bus.result, bus.flags, exp_v[W+3:4], exp_v[3:0]);
                    end
                end
            end
            tick();
        end
        checks++;
        if (i != 16 || sb.size() != 0) begin
            errors++;
            $display("FAIL vec_timeout: got sent=%0d pending=%0d expected sent=16 pending=0", i, sb.size());
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int i, emitted, ready_low;
        logic ordy, prev_stall;
        logic [W+3:0] prev_out, exp_v;
        i = 0; emitted = 0; ready_low = 0; prev_stall = 1'b0; prev_out = '0;
        sb.delete();
        for (int c = 0; c < 60 && (i < 8 || sb.size() > 0); c++) begin
            ordy = !(c >= 4 && c < 9);
            drive(i < 8, a_tab[(i + 8) % 16], b_tab[(i + 8) % 16], ordy, 1'b0);
            checks++;
            if (bus.in_ready !== !(bus.out_valid && !ordy)) begin
                errors++;
                $display("FAIL b2b_in_ready: got %b expected %b at cycle %0d", bus.in_ready, !(bus.out_valid && !ordy), c);
            end
            if (!bus.in_ready) ready_low++;
            if (prev_stall) begin
                checks++;
                if ({bus.result, bus.flags} !== prev_out) begin
                    errors++;
                    $display("FAIL b2b_hold: got %h/%b expected %h/%b", bus.result, bus.flags, prev_out[W+3:4], prev_out[3:0]);
                end
            end
            prev_stall = bus.out_valid && !ordy;
            prev_out   = {bus.result, bus.flags};
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back({r_tab[i + 8], f_tab[i + 8]});
                i++;
            end
            if (bus.out_valid && bus.out_ready) begin
                emitted++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_duplicate: got %h expected no output", bus.result);
                end else begin
                    exp_v = sb.pop_front();
                    if ({bus.result, bus.flags} !== exp_v) begin
                        errors++;
                        $display("FAIL b2b_order: got %h/%b expected %h/%b", bus.result, bus.flags, exp_v[W+3:4], exp_v[3:0]);
                    end
                end
            end
            tick();
        end
        checks++;
        if (emitted != 8 || i != 8) begin
            errors++;
            $display("FAIL b2b_count: got sent=%0d emitted=%0d expected 8/8", i, emitted);
        end
        checks++;
        if (ready_low != 5) begin
            errors++;
            $display("FAIL b2b_stall_len: got %0d expected 5", ready_low);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_clear();
        int seen;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, a_tab[k], b_tab[k], 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clear_full_pipe: got %b expected 1", bus.out_valid); end
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clear_next_cycle: got %b expected 0", bus.out_valid); end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL clear_emitted: got %0d expected 0", seen); end

        drive(1'b1, a_tab[5], b_tab[5], 1'b1, 1'b0);
        tick();
        drive(1'b1, a_tab[6], b_tab[6], 1'b1, 1'b1);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_ready: got %b expected 1", bus.in_ready); end
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL clear_drop_accept: got %0d expected 0", seen); end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, a_tab[k + 10], b_tab[k + 10], 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_full_pipe: got %b expected 1", bus.out_valid); end
        #2 reset_b = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL rst_immediate: got %b/%h/%b expected 0/0/0", bus.out_valid, bus.result, bus.flags);
        end
        tick();
        tick();
        reset_b = 1'b1;
        drive(1'b1, a_tab[5], b_tab[5], 1'b1, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_first_accept: got %b expected 1", bus.in_ready); end
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            checks++;
            if (bus.out_valid !== (e == 3)) begin
                errors++;
                $display("FAIL rst_after_edge%0d: got %b expected %b", e, bus.out_valid, (e == 3));
            end
            if (e < 3) tick();
        end
        checks++;
        if (bus.result !== r_tab[5] || bus.flags !== f_tab[5]) begin
            errors++;
            $display("FAIL rst_result: got %h/%b expected %h/%b", bus.result, bus.flags, r_tab[5], f_tab[5]);
        end
        tick();
    endtask

    initial begin
        init_tables();
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_clear();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
